// File: rtl/uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// uart_tx_cfg
// Parametrised UART transmitter. Serialises one word per frame onto tx:
// start bit, DATA_BITS data bits, optional parity bit, then 1 or 2 stop bits.
// Bit timing is taken from an external oversampling strobe (baud_tick); each
// bit lasts exactly OVERSAMPLE ticks. Words arrive over a valid/ready handshake.
//
// Optional feature macro: UART_TX_CFG_BREAK_EN
//   When defined, adds input break_req and a BREAK state that holds tx low
//   for at least (DATA_BITS+2)*OVERSAMPLE baud ticks and until break_req drops.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   baud_tick  in   one-clk strobe at OVERSAMPLE x baud rate
//   s_data     in   word to transmit (DATA_BITS wide)
//   s_valid    in   s_data valid
//   break_req  in   request a line break (only with UART_TX_CFG_BREAK_EN)
//   s_ready    out  block can accept a word (state is IDLE)
//   tx         out  registered serial line, idles high
//   busy       out  frame (or break) in progress
//   done       out  one-clk pulse in the cycle the block returns to IDLE
//                   after the last stop bit
// -----------------------------------------------------------------------------
module uart_tx_cfg #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int LSB_FIRST   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] s_data,
  input  logic                 s_valid,
`ifdef UART_TX_CFG_BREAK_EN
  input  logic                 break_req,
`endif
  output logic                 s_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS) + 1;

  // Elaboration-time parameter legality checks
  generate
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_cfg: DATA_BITS must be in 5..9");
    end
    if (OVERSAMPLE < 4 || OVERSAMPLE > 64) begin : g_bad_oversample
      $error("uart_tx_cfg: OVERSAMPLE must be in 4..64");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
      $error("uart_tx_cfg: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (LSB_FIRST < 0 || LSB_FIRST > 1) begin : g_bad_order
      $error("uart_tx_cfg: LSB_FIRST must be 0 or 1");
    end
  endgenerate

`ifdef UART_TX_CFG_BREAK_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  localparam int BRK_TICKS = (DATA_BITS + 2) * OVERSAMPLE;
  localparam int BRK_W     = $clog2(BRK_TICKS + 1);
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`endif

  state_t                r_state;
  state_t                w_state_next;
  logic [TICK_W-1:0]     r_tick_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic                  r_stop_cnt;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_parity;
  logic                  r_tx;
  logic                  r_done;

  logic                  w_tx_next;
  logic                  w_done_next;
  logic                  w_bit_end;
  logic                  w_accept;
  logic                  w_break_req;
  logic                  w_shift_out;
  logic                  w_last_data;
  logic                  w_last_stop;

`ifdef UART_TX_CFG_BREAK_EN
  logic [BRK_W-1:0]      r_brk_cnt;
  logic                  w_brk_elapsed;

  assign w_break_req   = break_req;
  assign w_brk_elapsed = (r_brk_cnt >= BRK_W'(BRK_TICKS));
`else
  assign w_break_req   = 1'b0;
`endif

  // A bit period closes on the tick that takes the counter past its top
  assign w_bit_end   = baud_tick && (r_tick_cnt == TICK_W'(OVERSAMPLE - 1));
  // Break wins over a simultaneous word offer
  assign w_accept    = (r_state == S_IDLE) && s_valid && !w_break_req;
  assign w_shift_out = (LSB_FIRST != 0) ? r_shift[0] : r_shift[DATA_BITS-1];
  assign w_last_data = (r_bit_cnt == BIT_W'(DATA_BITS - 1));
  assign w_last_stop = (r_stop_cnt == 1'(STOP_BITS - 1));

  // Next-state and registered-output decode
  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    w_tx_next    = 1'b1;

    case (r_state)
      S_IDLE: begin
        w_tx_next = 1'b1;
`ifdef UART_TX_CFG_BREAK_EN
        if (w_break_req) begin
          w_state_next = S_BREAK;
        end else
`endif
        if (s_valid) begin
          w_state_next = S_START;
        end
      end
      S_START: begin
        w_tx_next = 1'b0;
        if (w_bit_end) begin
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        w_tx_next = w_shift_out;
        if (w_bit_end && w_last_data) begin
          w_state_next = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        w_tx_next = r_parity;
        if (w_bit_end) begin
          w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        w_tx_next = 1'b1;
        if (w_bit_end && w_last_stop) begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
        end
      end
`ifdef UART_TX_CFG_BREAK_EN
      S_BREAK: begin
        w_tx_next = 1'b0;
        if (!w_break_req && w_brk_elapsed) begin
          w_state_next = S_IDLE;
        end
      end
`endif
      default: begin
        w_state_next = S_IDLE;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_tx    <= w_tx_next;
      r_done  <= w_done_next;
    end
  end

  // Frame datapath: tick/bit/stop counters, shift register, parity
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
    end else if (w_accept) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_shift    <= s_data;
      // Parity comes from the accepted word, odd mode inverts the XOR
      r_parity   <= (^s_data) ^ (PARITY_MODE == 1);
    end else begin
      // Ticks are counted only inside a frame, so a tick on the accept
      // edge never counts toward the start bit
      if (r_state == S_START || r_state == S_DATA ||
          r_state == S_PARITY || r_state == S_STOP) begin
        if (baud_tick) begin
          if (r_tick_cnt == TICK_W'(OVERSAMPLE - 1)) begin
            r_tick_cnt <= '0;
          end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
          end
        end
      end else begin
        r_tick_cnt <= '0;
      end

      if (r_state == S_DATA && w_bit_end) begin
        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
        if (LSB_FIRST != 0) begin
          r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
        end else begin
          r_shift <= {r_shift[DATA_BITS-2:0], 1'b0};
        end
      end

      if (r_state == S_STOP && w_bit_end && !w_last_stop) begin
        r_stop_cnt <= 1'b1;
      end
    end
  end

`ifdef UART_TX_CFG_BREAK_EN
  // Break duration counter, saturates at the minimum break length
  always_ff @(posedge clk) begin
    if (rst) begin
      r_brk_cnt <= '0;
    end else if (r_state == S_BREAK) begin
      if (baud_tick && !w_brk_elapsed) begin
        r_brk_cnt <= r_brk_cnt + BRK_W'(1);
      end
    end else begin
      r_brk_cnt <= '0;
    end
  end
`endif

  assign s_ready = (r_state == S_IDLE);
  assign busy    = (r_state != S_IDLE);
  assign tx      = r_tx;
  assign done    = r_done;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_cfg
// Three transmitter configurations share clock, reset and baud strobe:
//   dut0: 8 data, OS 16, no parity, 1 stop, LSB first
//   dut1: 7 data, OS 4,  odd parity, 2 stop, MSB first
//   dut2: 9 data, OS 5,  even parity, 1 stop, LSB first
// A per-configuration model tracks, for each accepted word, the number of
// baud ticks since acceptance and derives the line level from the frame's
// bit list. Outputs are compared on every falling edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_cfg;

  localparam int ND = 3;

  logic          clk;
  logic          rst;
  logic          baud_tick;
  logic [8:0]    s_data_w [ND];
  logic [ND-1:0] s_valid;
  logic [ND-1:0] break_req;
  logic [ND-1:0] s_ready;
  logic [ND-1:0] tx;
  logic [ND-1:0] busy;
  logic [ND-1:0] done;

  int pass_n;
  int tot_n;

  uart_tx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(1), .LSB_FIRST(1)) u_d0 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .s_data(s_data_w[0][7:0]), .s_valid(s_valid[0]),
`ifdef UART_TX_CFG_BREAK_EN
    .break_req(break_req[0]),
`endif
    .s_ready(s_ready[0]), .tx(tx[0]), .busy(busy[0]), .done(done[0]));

  uart_tx_cfg #(.DATA_BITS(7), .OVERSAMPLE(4), .PARITY_MODE(1), .STOP_BITS(2), .LSB_FIRST(0)) u_d1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .s_data(s_data_w[1][6:0]), .s_valid(s_valid[1]),
`ifdef UART_TX_CFG_BREAK_EN
    .break_req(break_req[1]),
`endif
    .s_ready(s_ready[1]), .tx(tx[1]), .busy(busy[1]), .done(done[1]));

  uart_tx_cfg #(.DATA_BITS(9), .OVERSAMPLE(5), .PARITY_MODE(2), .STOP_BITS(1), .LSB_FIRST(1)) u_d2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .s_data(s_data_w[2][8:0]), .s_valid(s_valid[2]),
`ifdef UART_TX_CFG_BREAK_EN
    .break_req(break_req[2]),
`endif
    .s_ready(s_ready[2]), .tx(tx[2]), .busy(busy[2]), .done(done[2]));

  // ---------------- configuration tables ----------------
  function automatic int p_db(int d);
    case (d) 0: return 8; 1: return 7; default: return 9; endcase
  endfunction
  function automatic int p_os(int d);
    case (d) 0: return 16; 1: return 4; default: return 5; endcase
  endfunction
  function automatic int p_pm(int d);
    case (d) 0: return 0; 1: return 1; default: return 2; endcase
  endfunction
  function automatic int p_sb(int d);
    case (d) 1: return 2; default: return 1; endcase
  endfunction
  function automatic int p_lsb(int d);
    case (d) 1: return 0; default: return 1; endcase
  endfunction
  function automatic int n_bits(int d);
    return 1 + p_db(d) + ((p_pm(d) != 0) ? 1 : 0) + p_sb(d);
  endfunction

  // Line level of bit i of the frame carrying word w
  function automatic logic frame_bit(int d, logic [8:0] w, int i);
    int   db;
    logic par;
    db  = p_db(d);
    par = 1'b0;
    for (int j = 0; j < db; j++) par = par ^ w[j];
    if (i == 0) return 1'b0;
    if (i <= db) return (p_lsb(d) != 0) ? w[i-1] : w[db-i];
    if (p_pm(d) != 0 && i == db + 1) return (p_pm(d) == 1) ? ~par : par;
    return 1'b1;
  endfunction

  // ---------------- reference model ----------------
  bit         m_busy   [ND];
  bit         m_brk    [ND];
  int         m_k      [ND];
  int         m_bk     [ND];
  int         m_frames [ND];
  logic [8:0] m_word   [ND];
  logic       e_tx     [ND];
  logic       e_done   [ND];

  always @(posedge clk) begin
    logic line_v;
    for (int d = 0; d < ND; d++) begin
      line_v = m_brk[d] ? 1'b0 :
               (m_busy[d] ? frame_bit(d, m_word[d], m_k[d] / p_os(d)) : 1'b1);
      e_done[d] = 1'b0;
      if (rst) begin
        m_busy[d] = 0;
        m_brk[d]  = 0;
        m_k[d]    = 0;
        m_bk[d]   = 0;
        e_tx[d]   = 1'b1;
      end else begin
        e_tx[d] = line_v;
        if (m_brk[d]) begin
          if (!break_req[d] && m_bk[d] >= (p_db(d) + 2) * p_os(d)) m_brk[d] = 0;
          else if (baud_tick && m_bk[d] < (p_db(d) + 2) * p_os(d)) m_bk[d]++;
        end else if (!m_busy[d]) begin
          if (break_req[d]) begin
            m_brk[d] = 1;
            m_bk[d]  = 0;
          end else if (s_valid[d]) begin
            m_busy[d] = 1;
            m_k[d]    = 0;
            m_word[d] = s_data_w[d];
          end
        end else if (baud_tick) begin
          m_k[d]++;
          if (m_k[d] == n_bits(d) * p_os(d)) begin
            m_busy[d]   = 0;
            e_done[d]   = 1'b1;
            m_frames[d]++;
          end
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(string name, int d, logic [31:0] got, logic [31:0] exp);
    tot_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s dut%0d t=%0t got=%0h exp=%0h", name, d, $time, got, exp);
  endtask

  bit   cmp_en;
  bit   cap_en     [ND];
  int   capn       [ND];
  logic cap        [ND][16];
  int   prev_k     [ND];
  int   dut_done_n [ND];

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int d = 0; d < ND; d++) begin
        chk("tx", d, tx[d], e_tx[d]);
        chk("busy", d, busy[d], m_busy[d] || m_brk[d]);
        chk("s_ready", d, s_ready[d], !(m_busy[d] || m_brk[d]));
        chk("done", d, done[d], e_done[d]);
        if (done[d] === 1'b1) dut_done_n[d]++;
        // Sample the line mid-bit for directed frames
        if (cap_en[d] && m_busy[d] && m_k[d] != prev_k[d] &&
            (m_k[d] % p_os(d)) == p_os(d) / 2 && capn[d] < 16) begin
          cap[d][capn[d]] = tx[d];
          capn[d]++;
        end
        prev_k[d] = m_k[d];
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(int d, logic [8:0] w);
    bit ok;
    s_data_w[d] = w;
    s_valid[d]  = 1'b1;
    for (int k = 0; k < 20000; k++) begin
      ok = s_ready[d] && !rst;
      @(negedge clk);
      if (ok) begin
        s_valid[d] = 1'b0;
        return;
      end
    end
    s_valid[d] = 1'b0;
    chk("accept_timeout", d, 0, 1);
  endtask

  task automatic wait_idle(int d);
    for (int k = 0; k < 20000; k++) begin
      if (!busy[d] && !m_busy[d] && !m_brk[d]) return;
      @(negedge clk);
    end
    chk("idle_timeout", d, 0, 1);
  endtask

  task automatic cap_start(int d);
    capn[d]   = 0;
    cap_en[d] = 1;
  endtask

  task automatic cap_check(int d, logic [8:0] w, logic [15:0] lit);
    int n;
    n         = n_bits(d);
    cap_en[d] = 0;
    chk("cap_count", d, capn[d], n);
    for (int i = 0; i < n; i++) begin
      chk("model_bit", d, frame_bit(d, w, i), lit[i]);
      if (i < capn[d]) chk("line_bit", d, cap[d][i], lit[i]);
    end
  endtask

  // ---------------- clock and baud strobe ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      baud_tick = ($urandom_range(0, 1) == 1);
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int saved_done;
    pass_n    = 0;
    tot_n     = 0;
    cmp_en    = 0;
    rst       = 1'b1;
    s_valid   = '0;
    break_req = '0;
    for (int d = 0; d < ND; d++) s_data_w[d] = '0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < ND; d++) begin
      chk("rst_tx", d, tx[d], 1);
      chk("rst_ready", d, s_ready[d], 1);
      chk("rst_busy", d, busy[d], 0);
      chk("rst_done", d, done[d], 0);
    end
    cmp_en = 1;

    // 8N1 frame of 0xA5
    cap_start(0);
    send(0, 9'h0A5);
    wait_idle(0);
    cap_check(0, 9'h0A5, 16'h034A);

    // Odd parity MSB-first 2-stop, and even parity 9-bit, concurrently
    fork
      begin cap_start(1); send(1, 9'h041); end
      begin cap_start(2); send(2, 9'h007); end
    join
    wait_idle(1);
    wait_idle(2);
    cap_check(1, 9'h041, 16'h0782);
    cap_check(2, 9'h007, 16'h0C0E);

    // Back-to-back words with s_valid held high
    send(0, 9'h011);
    send(0, 9'h022);
    wait_idle(0);

    // Reset 50 ticks into a frame, then a fresh frame
    send(0, 9'h000);
    for (int k = 0; k < 5000 && m_k[0] < 50; k++) @(negedge clk);
    if (m_k[0] < 50) chk("rst_wait", 0, 0, 1);
    saved_done = dut_done_n[0];
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_tx", 0, tx[0], 1);
    chk("midrst_busy", 0, busy[0], 0);
    repeat (40) @(negedge clk);
    chk("midrst_nodone", 0, dut_done_n[0], saved_done);
    cap_start(0);
    send(0, 9'h03C);
    wait_idle(0);
    cap_check(0, 9'h03C, 16'h0278);

`ifdef UART_TX_CFG_BREAK_EN
    // Break with a competing word offer; word goes out only after the break
    break_req[0] = 1'b1;
    s_data_w[0]  = 9'h05A;
    s_valid[0]   = 1'b1;
    for (int k = 0; k < 5000 && !(m_brk[0] && m_bk[0] >= 20); k++) @(negedge clk);
    chk("brk_entered", 0, busy[0] && !s_ready[0], 1);
    break_req[0] = 1'b0;
    send(0, 9'h05A);
    wait_idle(0);
`endif

    // Randomised traffic with occasional reset
    for (int c = 0; c < 4000; c++) begin
      for (int d = 0; d < ND; d++) begin
        s_valid[d]  = ($urandom_range(0, 3) != 0);
        s_data_w[d] = 9'($urandom);
      end
      rst = ($urandom_range(0, 799) == 0);
      @(negedge clk);
    end
    rst     = 1'b0;
    s_valid = '0;
    for (int d = 0; d < ND; d++) wait_idle(d);
    @(negedge clk);
    for (int d = 0; d < ND; d++) chk("done_total", d, dut_done_n[d], m_frames[d]);

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
